// File: rtl/delta_backprop_if.sv
// Handshake bundle for delta_backprop: delta vector in, weight matrix, accumulator stream out.
interface delta_backprop_if #(
    parameter int unsigned NP = 5,
    parameter int unsigned NC = 6,
    parameter int unsigned WV = 4
);
    localparam int unsigned WA = $clog2(NC) + WV;

    logic                   iValid_AM_Delta;
    logic                   oReady_AM_Delta;
    logic [NC*WV-1:0]       iData_AM_Delta;
    logic [NC*NP*WV-1:0]    iData_Weight;
    logic                   oValid_BM_Accum;
    logic                   iReady_BM_Accum;
    logic [NP*WA-1:0]       oData_BM_Accum;

    modport master (
        output iValid_AM_Delta, iData_AM_Delta, iData_Weight, iReady_BM_Accum,
        input  oReady_AM_Delta, oValid_BM_Accum, oData_BM_Accum
    );

    modport slave (
        input  iValid_AM_Delta, iData_AM_Delta, iData_Weight, iReady_BM_Accum,
        output oReady_AM_Delta, oValid_BM_Accum, oData_BM_Accum
    );
endinterface

// File: rtl/delta_backprop.sv
// Weighted error back-propagation: sum[p] = sum_c delta[c]*w[c][p], one child per cycle.
// Optional feature macro: DELTA_BACKPROP_OVERLAP_EN (accept next vector in the output handshake cycle).
module delta_backprop #(
    parameter int unsigned NP = 5,
    parameter int unsigned NC = 6,
    parameter int unsigned WV = 4
) (
    input logic             iCLK,
    input logic             iRST,
    delta_backprop_if.slave bus
);
    localparam int unsigned CW = (NC > 1) ? $clog2(NC) : 1;
    localparam int unsigned WA = $clog2(NC) + WV;
    localparam int unsigned PW = 2 * WV;
    localparam int unsigned DW = NC * WV;
    localparam int unsigned AW = NP * WA;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   delta_q;
    logic [AW-1:0]   acc;
    logic            valid_q;
    logic [AW-1:0]   term_c;
    logic            ready_c;
    logic            accept_c;
    logic            out_hs_c;

    // Ready is combinational so reset can force it low and the overlap mode can follow downstream ready.
    always_comb begin
        ready_c = 1'b0;
        if (!iRST) begin
            if (state == IDLE) begin
                ready_c = 1'b1;
            end
`ifdef DELTA_BACKPROP_OVERLAP_EN
            else if (state == OUT) begin
                ready_c = bus.iReady_BM_Accum;
            end
`endif
        end
    end

    assign accept_c = bus.iValid_AM_Delta && ready_c;
    assign out_hs_c = valid_q && bus.iReady_BM_Accum;

    // Per-lane Q1 product of the current child: floor shift, then clamp the lone (-1)*(-1) overflow.
    always_comb begin
        logic signed [WV-1:0] d;
        logic signed [WV-1:0] w;
        logic signed [PW-1:0] prod;
        logic signed [WV:0]   shr;
        logic signed [WV-1:0] sat;
        term_c = '0;
        w      = '0;
        prod   = '0;
        shr    = '0;
        sat    = '0;
        d      = delta_q[32'(cnt)*WV +: WV];
        for (int unsigned p = 0; p < NP; p++) begin
            w    = bus.iData_Weight[(32'(cnt)*NP + p)*WV +: WV];
            prod = PW'(d) * PW'(w);
            shr  = (WV+1)'(prod >>> (WV-1));
            if (shr[WV] != shr[WV-1]) begin
                sat = {1'b0, {(WV-1){1'b1}}};
            end else begin
                sat = shr[WV-1:0];
            end
            term_c[p*WA +: WA] = WA'(sat);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= IDLE;
            cnt     <= '0;
            delta_q <= '0;
            acc     <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        delta_q <= bus.iData_AM_Delta;
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    for (int unsigned p = 0; p < NP; p++) begin
                        acc[p*WA +: WA] <= acc[p*WA +: WA] + term_c[p*WA +: WA];
                    end
                    if (cnt == CW'(NC-1)) begin
                        cnt     <= '0;
                        valid_q <= 1'b1;
                        state   <= OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_hs_c) begin
                        valid_q <= 1'b0;
`ifdef DELTA_BACKPROP_OVERLAP_EN
                        if (accept_c) begin
                            delta_q <= bus.iData_AM_Delta;
                            acc     <= '0;
                            cnt     <= '0;
                            state   <= ACCUM;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oReady_AM_Delta = ready_c;
    assign bus.oValid_BM_Accum = valid_q;
    assign bus.oData_BM_Accum  = acc;

endmodule

// File: tb/tb_delta_backprop.sv
// Directed bench for delta_backprop: vector table plus reset, backpressure and abort sequences.
module tb_delta_backprop;
    localparam int unsigned NP = 5;
    localparam int unsigned NC = 6;
    localparam int unsigned WV = 4;
    localparam int unsigned WA = $clog2(NC) + WV;
    localparam int unsigned DW = NC * WV;
    localparam int unsigned WW = NC * NP * WV;
    localparam int unsigned AW = NP * WA;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    delta_backprop_if #(.NP(NP), .NC(NC), .WV(WV)) bus ();
    delta_backprop #(.NP(NP), .NC(NC), .WV(WV)) dut (.iCLK(clk), .iRST(rst), .bus(bus));

    typedef struct {
        string         name;
        logic [DW-1:0] d;
        logic [WW-1:0] w;
        logic [AW-1:0] exp;
    } vec_t;

    vec_t vt[6];
    int   nvec = 0;
    int   nmis = 0;

`ifdef DELTA_BACKPROP_OVERLAP_EN
    localparam int BP_LAT = 7;
    localparam int BP_RDY = 1;
`else
    localparam int BP_LAT = 8;
    localparam int BP_RDY = 0;
`endif

    function automatic logic [DW-1:0] rep_d(input int v);
        logic [DW-1:0] r = '0;
        for (int c = 0; c < NC; c++) r[c*WV +: WV] = WV'(v);
        return r;
    endfunction

    function automatic logic [DW-1:0] d6(input int a, input int b, input int c2,
                                         input int e, input int f, input int g);
        logic [DW-1:0] r = '0;
        int v[6] = '{a, b, c2, e, f, g};
        for (int c = 0; c < NC; c++) r[c*WV +: WV] = WV'(v[c]);
        return r;
    endfunction

    function automatic logic [WW-1:0] w_lane(input int a, input int b, input int c2,
                                             input int e, input int f);
        logic [WW-1:0] r = '0;
        int v[5] = '{a, b, c2, e, f};
        for (int c = 0; c < NC; c++)
            for (int p = 0; p < NP; p++) r[(c*NP+p)*WV +: WV] = WV'(v[p]);
        return r;
    endfunction

    function automatic logic [WW-1:0] rep_w(input int v);
        return w_lane(v, v, v, v, v);
    endfunction

    function automatic logic [AW-1:0] acc5(input int a, input int b, input int c2,
                                           input int e, input int f);
        logic [AW-1:0] r = '0;
        int v[5] = '{a, b, c2, e, f};
        for (int p = 0; p < NP; p++) r[p*WA +: WA] = WA'(v[p]);
        return r;
    endfunction

    function automatic logic [AW-1:0] rep_acc(input int v);
        return acc5(v, v, v, v, v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the acceptance edge.
    task automatic send(input logic [DW-1:0] d, input logic [WW-1:0] w);
        int n = 0;
        bus.iData_AM_Delta  = d;
        bus.iData_Weight    = w;
        bus.iValid_AM_Delta = 1'b1;
        #1;
        while (!bus.oReady_AM_Delta && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_wait", 64'(bus.oReady_AM_Delta), 64'd1);
        @(negedge clk);
        bus.iValid_AM_Delta = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int n);
        n = start;
        while (!bus.oValid_BM_Accum && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic apply(input vec_t v);
        int n;
        bus.iReady_BM_Accum = 1'b1;
        send(v.d, v.w);
        wait_valid(1, n);
        chk({v.name, "_latency"}, 64'(n), 64'd7);
        chk({v.name, "_data"}, 64'(bus.oData_BM_Accum), 64'(v.exp));
        @(negedge clk);
        chk({v.name, "_valid_drop"}, 64'(bus.oValid_BM_Accum), 64'd0);
        chk({v.name, "_ready_back"}, 64'(bus.oReady_AM_Delta), 64'd1);
    endtask

    task automatic hold_reset(input string nm);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk({nm, "_rst_ready"}, 64'(bus.oReady_AM_Delta), 64'd0);
            chk({nm, "_rst_valid"}, 64'(bus.oValid_BM_Accum), 64'd0);
            chk({nm, "_rst_data"}, 64'(bus.oData_BM_Accum), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk({nm, "_rel_ready"}, 64'(bus.oReady_AM_Delta), 64'd1);
    endtask

    task automatic no_output(input string nm);
        int seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.oValid_BM_Accum) seen++;
        end
        chk({nm, "_no_output"}, 64'(seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst                 = 1'b1;
        bus.iValid_AM_Delta = 1'b0;
        bus.iData_AM_Delta  = '0;
        bus.iData_Weight    = '0;
        bus.iReady_BM_Accum = 1'b1;

        vt[0] = '{"all4",    rep_d(4),                    rep_w(4),             rep_acc(12)};
        vt[1] = '{"sat",     rep_d(-8),                   rep_w(-8),            rep_acc(42)};
        vt[2] = '{"floor",   d6(1, -1, 1, -1, 1, -1),     rep_w(7),             rep_acc(-3)};
        vt[3] = '{"neg_max", rep_d(-8),                   rep_w(7),             rep_acc(-42)};
        vt[4] = '{"lanes",   rep_d(4),                    w_lane(0, 1, 2, 3, 4), acc5(0, 0, 6, 6, 12)};
        vt[5] = '{"mixed",   d6(7, -8, 3, 0, -1, 2),      rep_w(-7),            rep_acc(-5)};

        @(negedge clk);
        hold_reset("init");

        for (int i = 0; i < 6; i++) apply(vt[i]);

        // Backpressure: result held 10 cycles while the next vector waits.
        bus.iReady_BM_Accum = 1'b0;
        send(rep_d(4), rep_w(4));
        wait_valid(1, n);
        chk("bp_latency", 64'(n), 64'd7);
        bus.iData_AM_Delta  = rep_d(-8);
        bus.iData_Weight    = rep_w(-8);
        bus.iValid_AM_Delta = 1'b1;
        repeat (10) begin
            chk("bp_valid_hold", 64'(bus.oValid_BM_Accum), 64'd1);
            chk("bp_data_hold", 64'(bus.oData_BM_Accum), 64'(rep_acc(12)));
            chk("bp_ready_low", 64'(bus.oReady_AM_Delta), 64'd0);
            @(negedge clk);
        end
        bus.iReady_BM_Accum = 1'b1;
        #1;
        chk("bp_hs_ready", 64'(bus.oReady_AM_Delta), 64'(BP_RDY));
        @(negedge clk);
        chk("bp_valid_drop", 64'(bus.oValid_BM_Accum), 64'd0);
        @(negedge clk);
        bus.iValid_AM_Delta = 1'b0;
        wait_valid(2, n);
        chk("bp_next_latency", 64'(n), 64'(BP_LAT));
        chk("bp_next_data", 64'(bus.oData_BM_Accum), 64'(rep_acc(42)));
        @(negedge clk);

        // Reset while accumulating child 3, then a fresh vector.
        send(rep_d(-8), rep_w(-8));
        repeat (3) @(negedge clk);
        hold_reset("abort_accum");
        no_output("abort_accum");
        apply(vt[0]);

        // Reset while a result waits in OUT.
        bus.iReady_BM_Accum = 1'b0;
        send(rep_d(4), rep_w(4));
        wait_valid(1, n);
        chk("abort_out_latency", 64'(n), 64'd7);
        hold_reset("abort_out");
        bus.iReady_BM_Accum = 1'b1;
        no_output("abort_out");
        apply(vt[5]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
